// File: rtl/prog_tick_delay.sv
`default_nettype none
// ============================================================================
//  Module      : prog_tick_delay
//  Description : Runtime-programmable tick delay line. Valid-tagged samples
//                travel through a circular buffer and emerge exactly D cycles
//                after acceptance. D is changed through a cfg handshake; the
//                controller drains in-flight samples before switching D.
//  Option      : `define PROG_TICK_DELAY_CFG_ERR_EN adds a sticky cfg_err_o
//                output flagging out-of-range delay requests.
//  Revision    : 1.0 - initial release
// ============================================================================
module prog_tick_delay #(
    parameter  int DATAWIDTH     = 8,
    parameter  int MAX_DELAY     = 16,
    parameter  int DEFAULT_DELAY = 1,
    localparam int DW_D          = $clog2(MAX_DELAY + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [DATAWIDTH-1:0] data_i,
    output logic                 valid_o,
    output logic [DATAWIDTH-1:0] data_o,
    input  logic                 cfg_valid_i,
    input  logic [DW_D-1:0]      cfg_delay_i,
    output logic                 cfg_ready_o,
    output logic [DW_D-1:0]      delay_o,
    output logic                 busy_o
`ifdef PROG_TICK_DELAY_CFG_ERR_EN
    ,
    output logic                 cfg_err_o
`endif
);

    // Pointer width; a single-entry buffer still needs one bit.
    localparam int              PW       = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
    localparam int              SW       = DW_D + 1;
    localparam logic [DW_D-1:0] MAX_D    = DW_D'(MAX_DELAY);
    localparam logic [DW_D-1:0] DEF_D    = DW_D'(DEFAULT_DELAY);
    localparam logic [PW-1:0]   LAST_PTR = PW'(MAX_DELAY - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_APPLY = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [DW_D-1:0]        delay_q;
    logic [DW_D-1:0]        inflight;
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [SW-1:0]          rd_sum;
    logic [MAX_DELAY-1:0]   vbits;
    logic [DATAWIDTH-1:0]   mem [MAX_DELAY];
    logic                   accept;
    logic                   zero_d;
    logic                   in_apply;
    logic [DW_D-1:0]        clamped;

    assign accept   = valid_i & ready_o;
    assign zero_d   = (delay_q == '0);
    assign in_apply = (state == ST_APPLY);
    assign clamped  = (cfg_delay_i > MAX_D) ? MAX_D : cfg_delay_i;
    assign delay_o  = delay_q;

    // Read pointer = (wr_ptr - D) mod MAX_DELAY, computed without going negative.
    always_comb begin
        rd_sum = SW'(wr_ptr) + SW'(MAX_DELAY) - SW'(delay_q);
        if (rd_sum >= SW'(MAX_DELAY)) begin
            rd_sum = rd_sum - SW'(MAX_DELAY);
        end
        rd_ptr = PW'(rd_sum);
    end

    // Output mux: D=0 bypasses storage, otherwise the tagged entry at rd_ptr.
    always_comb begin
        valid_o = zero_d ? accept : vbits[rd_ptr];
        data_o  = '0;
        if (valid_o) begin
            data_o = zero_d ? data_i : mem[rd_ptr];
        end
    end

    // Write pointer free-runs every cycle regardless of valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
        end else if (wr_ptr == LAST_PTR) begin
            wr_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(1);
        end
    end

    // Data storage is deliberately unreset; the valid tags gate its use.
    always_ff @(posedge clk) begin
        mem[wr_ptr] <= data_i;
    end

    // Valid tags: written every cycle, wiped when a new delay takes effect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vbits <= '0;
        end else if (in_apply) begin
            vbits <= '0;
        end else begin
            vbits[wr_ptr] <= accept;
        end
    end

    // In-flight sample count; stays at zero in passthrough mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
        end else if (!zero_d) begin
            case ({accept, valid_o})
                2'b10:   inflight <= inflight + DW_D'(1);
                2'b01:   inflight <= inflight - DW_D'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // Active delay register, loaded with the clamped request in APPLY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            delay_q <= DEF_D;
        end else if (in_apply) begin
            delay_q <= clamped;
        end
    end

`ifdef PROG_TICK_DELAY_CFG_ERR_EN
    // Sticky flag for requests beyond MAX_DELAY; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err_o <= 1'b0;
        end else if (in_apply && (cfg_delay_i > MAX_D)) begin
            cfg_err_o <= 1'b1;
        end
    end
`endif

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Controller next state and handshake outputs. DRAIN does not look at
    // cfg_valid_i, so a withdrawn request still ends back in RUN.
    always_comb begin
        state_nxt   = state;
        ready_o     = 1'b0;
        busy_o      = 1'b1;
        cfg_ready_o = 1'b0;
        case (state)
            ST_RUN: begin
                ready_o = 1'b1;
                busy_o  = 1'b0;
                if (cfg_valid_i) begin
                    state_nxt = (inflight == '0) ? ST_APPLY : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (inflight == '0) begin
                    state_nxt = ST_APPLY;
                end
            end
            ST_APPLY: begin
                cfg_ready_o = 1'b1;
                state_nxt   = ST_RUN;
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

endmodule
`default_nettype wire
